// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: four fp32 ops time-multiplexed over one shared ALU.
// The falu below is a compact IEEE-754 single-precision unit (RNE, subnormals flushed to zero).
module falu (
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    localparam logic [31:0] QNAN = 32'h7fc00000;

    // x holds the significand with bit 51 weighted as 2^(e-127); normalise, round to nearest even, pack.
    function automatic logic [31:0] round_pack(input logic s, input int e_in, input logic [51:0] x_in);
        logic [51:0] x;
        logic [24:0] m;
        logic        up;
        int          e;
        x = x_in;
        e = e_in;
        for (int i = 0; i < 52; i++)
            if (!x[51]) begin
                x = x << 1;
                e = e - 1;
            end
        up = x[27] & ((|x[26:0]) | x[28]);
        m  = {1'b0, x[51:28]} + {24'd0, up};
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    logic        sa, sb, za, zb, ia, ib, na, nb, big_s, rem_nz;
    logic [23:0] ma, mb;
    logic [47:0] prod;
    logic [51:0] xa, xb, mask, xs, q52;
    logic [73:0] num, den;
    int          ea, eb, e_big, d;

    always_comb begin
        sa = a[31];
        sb = b[31] ^ (op == 2'b01);
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        big_s = 1'b0; e_big = 0; d = 0;
        xa = '0; xb = '0; mask = '0; xs = '0; q52 = '0;
        prod = '0; num = '0; den = '0; rem_nz = 1'b0;
        y = QNAN;
        case (op)
            2'b00, 2'b01: begin
                if (na || nb || (ia && ib && (sa != sb))) y = QNAN;
                else if (ia) y = {sa, 8'hff, 23'd0};
                else if (ib) y = {sb, 8'hff, 23'd0};
                else if (za && zb) y = {sa & sb, 31'd0};
                else if (za) y = {sb, b[30:0]};
                else if (zb) y = a;
                else begin
                    if (b[30:0] > a[30:0]) begin
                        big_s = sb; e_big = eb; d = eb - ea;
                        xa = {2'b01, b[22:0], 27'd0};
                        xb = {2'b01, a[22:0], 27'd0};
                    end else begin
                        big_s = sa; e_big = ea; d = ea - eb;
                        xa = {2'b01, a[22:0], 27'd0};
                        xb = {2'b01, b[22:0], 27'd0};
                    end
                    // bits shifted out of the smaller operand collapse into a sticky lsb
                    mask = (52'd1 << d) - 52'd1;
                    xs   = (xb >> d) | {51'd0, |(xb & mask)};
                    xs   = (sa == sb) ? xa + xs : xa - xs;
                    y    = (xs == '0) ? 32'd0 : round_pack(big_s, e_big + 1, xs);
                end
            end
            2'b10: begin
                if (na || nb || (ia && zb) || (za && ib)) y = QNAN;
                else if (ia || ib) y = {sa ^ sb, 8'hff, 23'd0};
                else if (za || zb) y = {sa ^ sb, 31'd0};
                else begin
                    prod = {24'd0, ma} * {24'd0, mb};
                    y    = round_pack(sa ^ sb, ea + eb - 126, {prod, 4'd0});
                end
            end
            default: begin
                if (na || nb || (ia && ib) || (za && zb)) y = QNAN;
                else if (ia || zb) y = {sa ^ sb, 8'hff, 23'd0};
                else if (za || ib) y = {sa ^ sb, 31'd0};
                else begin
                    num    = {ma, 50'd0};
                    den    = {50'd0, mb};
                    q52    = 52'(num / den);
                    rem_nz = (num % den) != 74'd0;
                    y      = round_pack(sa ^ sb, ea - eb + 128, {q52[51:1], q52[0] | rem_nz});
                end
            end
        endcase
    end
endmodule

module lif_neuron #(
    parameter logic [31:0] V_INIT  = 32'h00000000,
    parameter logic [31:0] V_TH    = 32'h3f800000,
    parameter logic [31:0] V_RESET = 32'h00000000,
    parameter logic [31:0] DECAY   = 32'h3f000000,
    parameter logic [31:0] GAIN    = 32'h3f800000,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      i_in,
    output logic             ready,
    output logic             done,
    output logic             spike,
    output logic [31:0]      v_out,
    output logic [CNT_W-1:0] spike_count
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_MULV = 3'd1;
    localparam logic [2:0] S_MULI = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_CMP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  state;
    logic [31:0] i_reg, t1, t2, vn;
    logic [1:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        fire, vn_nan;

    always_comb begin
        alu_op = 2'b00;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            S_MULV:  begin alu_op = 2'b10; alu_a = v_out; alu_b = DECAY; end
            S_MULI:  begin alu_op = 2'b10; alu_a = i_reg; alu_b = GAIN;  end
            S_ADD:   begin alu_op = 2'b00; alu_a = t1;    alu_b = t2;    end
            S_CMP:   begin alu_op = 2'b01; alu_a = vn;    alu_b = V_TH;  end
            default: ;
        endcase
    end

    falu u_falu (.op(alu_op), .a(alu_a), .b(alu_b), .y(alu_y));

    // a -0.0 difference means vn == V_TH exactly, which must fire
    assign fire   = !alu_y[31] || (alu_y[30:0] == 31'd0);
    assign vn_nan = (&vn[30:23]) && (|vn[22:0]);
    assign ready  = (state == IDLE);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            i_reg       <= '0;
            t1          <= '0;
            t2          <= '0;
            vn          <= '0;
            v_out       <= V_INIT;
            spike       <= 1'b0;
            spike_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    i_reg <= i_in;
                    state <= S_MULV;
                end
                S_MULV: begin t1 <= alu_y; state <= S_MULI; end
                S_MULI: begin t2 <= alu_y; state <= S_ADD;  end
                S_ADD:  begin vn <= alu_y; state <= S_CMP;  end
                S_CMP: begin
                    if (vn_nan) begin
                        v_out <= V_RESET;
                        spike <= 1'b0;
                    end else if (fire) begin
                        v_out <= V_RESET;
                        spike <= 1'b1;
                        if (!(&spike_count)) spike_count <= spike_count + 1'b1;
                    end else begin
                        v_out <= vn;
                        spike <= 1'b0;
                    end
                    state <= S_DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default instance plus a 2-bit-counter instance for saturation.
module tb_lif_neuron;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] i0 = '0, i1 = '0;
    logic        ready0, done0, spike0, ready1, done1, spike1;
    logic [31:0] v0, v1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
    int n_cmp = 0;
    int n_bad = 0;

    lif_neuron dut0 (.clk(clk), .rst(rst), .start(start0), .i_in(i0), .ready(ready0), .done(done0),
                     .spike(spike0), .v_out(v0), .spike_count(cnt0));
    lif_neuron #(.CNT_W(2)) dut1 (.clk(clk), .rst(rst), .start(start1), .i_in(i1), .ready(ready1),
                     .done(done1), .spike(spike1), .v_out(v1), .spike_count(cnt1));

    task automatic wait_ready(input int sel);
        for (int g = 0; g < 20; g++) begin
            if ((sel == 0 ? ready0 : ready1) === 1'b1) break;
            @(posedge clk); #1;
        end
    endtask

    // Issue one request; lat = cycles from acceptance edge to first observed done (-1 on timeout).
    task automatic req(input int sel, input logic [31:0] val, output int lat);
        wait_ready(sel);
        if (sel == 0) begin start0 = 1'b1; i0 = val; end
        else begin start1 = 1'b1; i1 = val; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if ((sel == 0 ? done0 : done1) === 1'b1) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done0); end
        n_cmp++; if (spike0 !== 1'b0) begin n_bad++; $display("FAIL reset_spike: got %b expected 0", spike0); end
        n_cmp++; if (v0 !== 32'h00000000) begin n_bad++; $display("FAIL reset_v: got %h expected 00000000", v0); end
        n_cmp++; if (cnt0 !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", cnt0); end
        n_cmp++; if (cnt1 !== 2'd0) begin n_bad++; $display("FAIL reset_cnt2: got %0d expected 0", cnt1); end
        rst = 1'b0;
    endtask

    task automatic test_integration();
        logic [31:0] exp_v [3] = '{32'h3f000000, 32'h3f400000, 32'h3f600000};
        int lat;
        for (int j = 0; j < 3; j++) begin
            req(0, 32'h3f000000, lat);
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL integ_lat[%0d]: got %0d expected 4", j, lat); end
            n_cmp++; if (v0 !== exp_v[j]) begin n_bad++; $display("FAIL integ_v[%0d]: got %h expected %h", j, v0, exp_v[j]); end
            n_cmp++; if (spike0 !== 1'b0) begin n_bad++; $display("FAIL integ_spike[%0d]: got %b expected 0", j, spike0); end
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen = 0;
        wait_ready(0);
        start0 = 1'b1; i0 = 32'h3f000000;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b expected 1", ready0); end
        n_cmp++; if (v0 !== 32'h00000000) begin n_bad++; $display("FAIL abort_v: got %h expected 00000000", v0); end
        for (int n = 0; n < 8; n++) begin
            if (done0 === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
        req(0, 32'h3f000000, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL abort_fresh_lat: got %0d expected 4", lat); end
        n_cmp++; if (v0 !== 32'h3f000000) begin n_bad++; $display("FAIL abort_fresh_v: got %h expected 3f000000", v0); end
    endtask

    task automatic test_threshold();
        int lat;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        req(0, 32'h3f800000, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL thr_lat: got %0d expected 4", lat); end
        n_cmp++; if (spike0 !== 1'b1) begin n_bad++; $display("FAIL thr_spike: got %b expected 1", spike0); end
        n_cmp++; if (v0 !== 32'h00000000) begin n_bad++; $display("FAIL thr_v: got %h expected 00000000", v0); end
        n_cmp++; if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL thr_cnt: got %0d expected 1", cnt0); end
    endtask

    // A start raised while busy, with a different i_in, must neither disturb nor queue.
    task automatic test_ignored_start();
        int lat = -1;
        int extra = 0;
        wait_ready(0);
        start0 = 1'b1; i0 = 32'h3f000000;
        @(posedge clk); #1;
        i0 = 32'h40000000;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int n = 2; n <= 12; n++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) begin lat = n; break; end
        end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ign_lat: got %0d expected 4", lat); end
        n_cmp++; if (v0 !== 32'h3f000000) begin n_bad++; $display("FAIL ign_v: got %h expected 3f000000", v0); end
        n_cmp++; if (spike0 !== 1'b0) begin n_bad++; $display("FAIL ign_spike: got %b expected 0", spike0); end
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ign_queued: got %0d dones expected 0", extra); end
    endtask

    task automatic test_throughput();
        logic exp_rdy, exp_done;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        start0 = 1'b1; i0 = 32'h40000000;
        for (int c = 0; c < 24; c++) begin
            exp_rdy = (c % 6 == 0);
            n_cmp++; if (ready0 !== exp_rdy) begin n_bad++; $display("FAIL tput_ready[%0d]: got %b expected %b", c, ready0, exp_rdy); end
            @(posedge clk); #1;
            exp_done = (c % 6 == 4);
            n_cmp++; if (done0 !== exp_done) begin n_bad++; $display("FAIL tput_done[%0d]: got %b expected %b", c, done0, exp_done); end
            if (exp_done) begin
                n_cmp++; if (spike0 !== 1'b1) begin n_bad++; $display("FAIL tput_spike[%0d]: got %b expected 1", c, spike0); end
                n_cmp++; if (cnt0 !== 16'(c / 6 + 1)) begin n_bad++; $display("FAIL tput_cnt[%0d]: got %0d expected %0d", c, cnt0, c / 6 + 1); end
            end
        end
        start0 = 1'b0;
        n_cmp++; if (cnt0 !== 16'd4) begin n_bad++; $display("FAIL tput_cnt_final: got %0d expected 4", cnt0); end
    endtask

    task automatic test_saturation();
        int exp_c [5] = '{1, 2, 3, 3, 3};
        int lat;
        for (int j = 0; j < 5; j++) begin
            req(1, 32'h40000000, lat);
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL sat_lat[%0d]: got %0d expected 4", j, lat); end
            n_cmp++; if (spike1 !== 1'b1) begin n_bad++; $display("FAIL sat_spike[%0d]: got %b expected 1", j, spike1); end
            n_cmp++; if (cnt1 !== 2'(exp_c[j])) begin n_bad++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", j, cnt1, exp_c[j]); end
        end
    endtask

    task automatic test_nan();
        int lat;
        req(1, 32'h3f000000, lat);
        n_cmp++; if (v1 !== 32'h3f000000) begin n_bad++; $display("FAIL nan_pre_v: got %h expected 3f000000", v1); end
        req(1, 32'h7fc00000, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL nan_lat: got %0d expected 4", lat); end
        n_cmp++; if (spike1 !== 1'b0) begin n_bad++; $display("FAIL nan_spike: got %b expected 0", spike1); end
        n_cmp++; if (v1 !== 32'h00000000) begin n_bad++; $display("FAIL nan_v: got %h expected 00000000", v1); end
        n_cmp++; if (cnt1 !== 2'd3) begin n_bad++; $display("FAIL nan_cnt: got %0d expected 3", cnt1); end
    endtask

    initial begin
        test_reset();
        test_integration();
        test_abort();
        test_threshold();
        test_ignored_start();
        test_throughput();
        test_saturation();
        test_nan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
